processor_multicycle_control: RTL and testbench

Multi-cycle control FSM for the MIPS-subset processor; successor to the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states, driving the shared-memory multi-cycle datapath. Adds ADDI and J support, a memory-ready wait handshake and an illegal-opcode trap. Sits between the instruction register's opcode field and the datapath control inputs.

---
 rtl/processor_multicycle_control_pkg.sv | 78 +++++++
 rtl/processor_multicycle_control_if.sv | 37 +++
 rtl/processor_ctl_state_decode.sv | 78 +++++++
 rtl/processor_multicycle_control.sv | 84 ++++++++
 tb/tb_processor_multicycle_control.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/processor_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control path: state encoding,
// opcode values, datapath select encodings and the decoded control bundle.
package processor_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALU_OP_W = 2;

  // Binary-encoded controller states; FETCH must stay at zero.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } ctl_state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // Full set of datapath controls produced for one cycle.
  typedef struct packed {
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          pc_src;
    logic                illegal_op;
  } ctl_t;

  // Maps an opcode to the state following DECODE; unrecognised opcodes map to TRAP.
  function automatic ctl_state_t decode_opcode(input logic [OPCODE_W-1:0] op);
    ctl_state_t nxt;
    case (op)
      OP_RTYPE: nxt = EXEC;
      OP_LW:    nxt = MEMADR;
      OP_SW:    nxt = MEMADR;
      OP_BEQ:   nxt = BRANCH;
      OP_ADDI:  nxt = ADDIEX;
      OP_J:     nxt = JUMP;
      default:  nxt = TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/processor_multicycle_control_if.sv
// Bundle between the control FSM (master) and the multi-cycle datapath
// (slave): opcode and memory handshake in, datapath controls out.
interface processor_multicycle_control_if #(
  parameter int OPCODE_W = processor_pkg::OPCODE_W,
  parameter int ALU_OP_W = processor_pkg::ALU_OP_W
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          pc_src;
  logic                illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op
  );
endinterface

// File: rtl/processor_ctl_state_decode.sv
// Moore output decode: maps the current controller state (plus the memory
// handshake, which only gates the fetch-time writes) to datapath controls.
module processor_ctl_state_decode
  import processor_pkg::*;
(
  input  ctl_state_t state_i,
  input  logic       mem_ready_i,
  output ctl_t       ctl_o
);

  // Per-state control values; anything not set stays inactive.
  always_comb begin
    ctl_o = '0;
    case (state_i)
      FETCH: begin
        ctl_o.mem_read  = 1'b1;
        ctl_o.i_or_d    = 1'b0;
        ctl_o.alu_src_a = 1'b0;
        ctl_o.alu_src_b = ALUB_FOUR;
        ctl_o.alu_op    = ALU_OP_ADD;
        // IR and PC only update once the instruction word is actually there.
        ctl_o.ir_write  = mem_ready_i;
        ctl_o.pc_write  = mem_ready_i;
      end
      DECODE: begin
        ctl_o.alu_src_b = ALUB_IMM_SH;
        ctl_o.alu_op    = ALU_OP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctl_o.alu_src_a = 1'b1;
        ctl_o.alu_src_b = ALUB_IMM;
      end
      MEMRD: begin
        ctl_o.mem_read = 1'b1;
        ctl_o.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctl_o.reg_write  = 1'b1;
        ctl_o.mem_to_reg = 1'b1;
        ctl_o.reg_dst    = 1'b0;
      end
      MEMWR: begin
        ctl_o.mem_write = 1'b1;
        ctl_o.i_or_d    = 1'b1;
      end
      EXEC: begin
        ctl_o.alu_src_a = 1'b1;
        ctl_o.alu_op    = ALU_OP_FUNCT;
      end
      ALUWB: begin
        ctl_o.reg_write = 1'b1;
        ctl_o.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctl_o.alu_src_a     = 1'b1;
        ctl_o.alu_op        = ALU_OP_SUB;
        ctl_o.pc_write_cond = 1'b1;
        ctl_o.pc_src        = PC_SRC_ALUOUT;
      end
      ADDIWB: begin
        ctl_o.reg_write = 1'b1;
        ctl_o.reg_dst   = 1'b0;
      end
      JUMP: begin
        ctl_o.pc_write = 1'b1;
        ctl_o.pc_src   = PC_SRC_JUMP;
      end
      TRAP: begin
        ctl_o.illegal_op = 1'b1;
      end
      default: begin
        // Unreachable encodings report as a trap with no strobes.
        ctl_o.illegal_op = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/processor_multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back,
// waits on the memory handshake and traps on unsupported opcodes.
module processor_multicycle_control
  import processor_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  processor_multicycle_control_if.master bus
);

  ctl_state_t state_q;
  ctl_state_t state_d;
  ctl_t       dec_ctl_s;
  ctl_t       ctl_s;

  // Next-state selection from the current state, opcode and memory handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready) state_d = DECODE;
        else               state_d = FETCH;
      end
      DECODE: state_d = decode_opcode(bus.opcode);
      MEMADR: begin
        // IR is held, so the same opcode picks the load or store path.
        if (bus.opcode == OP_LW)      state_d = MEMRD;
        else if (bus.opcode == OP_SW) state_d = MEMWR;
        else                          state_d = TRAP;
      end
      MEMRD: begin
        if (bus.mem_ready) state_d = MEMWB;
        else               state_d = MEMRD;
      end
      MEMWB:  state_d = FETCH;
      MEMWR: begin
        if (bus.mem_ready) state_d = FETCH;
        else               state_d = MEMWR;
      end
      EXEC:    state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  processor_ctl_state_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .ctl_o       (dec_ctl_s)
  );

  // Reset forces every control low so no partial write-back can escape.
  always_comb begin
    if (rst) ctl_s = '0;
    else     ctl_s = dec_ctl_s;
  end

  assign bus.pc_write      = ctl_s.pc_write;
  assign bus.pc_write_cond = ctl_s.pc_write_cond;
  assign bus.i_or_d        = ctl_s.i_or_d;
  assign bus.mem_read      = ctl_s.mem_read;
  assign bus.mem_write     = ctl_s.mem_write;
  assign bus.ir_write      = ctl_s.ir_write;
  assign bus.mem_to_reg    = ctl_s.mem_to_reg;
  assign bus.reg_dst       = ctl_s.reg_dst;
  assign bus.reg_write     = ctl_s.reg_write;
  assign bus.alu_src_a     = ctl_s.alu_src_a;
  assign bus.alu_src_b     = ctl_s.alu_src_b;
  assign bus.alu_op        = ctl_s.alu_op;
  assign bus.pc_src        = ctl_s.pc_src;
  assign bus.illegal_op    = ctl_s.illegal_op;

endmodule

// File: tb/tb_processor_multicycle_control.sv
// Directed, table-driven bench for the multi-cycle control FSM. Each table
// row is one clock cycle: inputs held for the cycle and the full expected
// control word sampled mid-cycle.
module tb_processor_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;

  processor_multicycle_control_if bus ();

  processor_multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] T_R   = 6'b000000;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100;
  localparam logic [5:0] T_ADI = 6'b001000;
  localparam logic [5:0] T_J   = 6'b000010;
  localparam logic [5:0] T_BAD = 6'b111111;

  // Word layout: pc_write pc_write_cond i_or_d mem_read mem_write ir_write
  // mem_to_reg reg_dst reg_write alu_src_a alu_src_b[2] alu_op[2] pc_src[2] illegal_op
  localparam logic [16:0] E_ZERO   = 17'h0;
  localparam logic [16:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_FETCHW = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_DECODE = {10'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMADR = {9'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMRD  = {2'b0,1'b1,1'b1,1'b0,5'b0,7'b0};
  localparam logic [16:0] E_MEMWB  = {6'b0,1'b1,1'b0,1'b1,1'b0,7'b0};
  localparam logic [16:0] E_MEMWR  = {2'b0,1'b1,1'b0,1'b1,5'b0,7'b0};
  localparam logic [16:0] E_EXEC   = {9'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] E_ALUWB  = {7'b0,1'b1,1'b1,1'b0,7'b0};
  localparam logic [16:0] E_BRANCH = {1'b0,1'b1,7'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] E_ADDIEX = {9'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_ADDIWB = {8'b0,1'b1,1'b0,7'b0};
  localparam logic [16:0] E_JUMP   = {1'b1,9'b0,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] E_TRAP   = {16'b0,1'b1};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [16:0] act_s;

  assign act_s = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_src, bus.illegal_op};

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [16:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs just after the edge, check mid-cycle, advance.
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [16:0] exp, input string tag, input int idx);
    rst = r;
    bus.opcode = op;
    bus.mem_ready = rdy;
    #4;
    n_total++;
    if (act_s === exp) n_pass++;
    else $display("FAIL %s[%0d]: ctl got %b expected %b", tag, idx, act_s, exp);
    n_total++;
    if (!(bus.pc_write === 1'b1 && bus.reg_write === 1'b1)) n_pass++;
    else $display("FAIL %s[%0d] pcw_regw_overlap: got 1 expected 0", tag, idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.opcode = 6'b0;
    bus.mem_ready = 1'b1;

    // Reset, then R-type
    add(1'b1, T_R, 1'b1, E_ZERO);
    add(1'b0, T_R, 1'b1, E_FETCH);
    add(1'b0, T_R, 1'b1, E_DECODE);
    add(1'b0, T_R, 1'b1, E_EXEC);
    add(1'b0, T_R, 1'b1, E_ALUWB);
    // LW with two wait cycles in MEMRD
    add(1'b0, T_LW, 1'b1, E_FETCH);
    add(1'b0, T_LW, 1'b1, E_DECODE);
    add(1'b0, T_LW, 1'b1, E_MEMADR);
    add(1'b0, T_LW, 1'b0, E_MEMRD);
    add(1'b0, T_LW, 1'b0, E_MEMRD);
    add(1'b0, T_LW, 1'b1, E_MEMRD);
    add(1'b0, T_LW, 1'b1, E_MEMWB);
    // SW, zero wait
    add(1'b0, T_SW, 1'b1, E_FETCH);
    add(1'b0, T_SW, 1'b1, E_DECODE);
    add(1'b0, T_SW, 1'b1, E_MEMADR);
    add(1'b0, T_SW, 1'b1, E_MEMWR);
    // BEQ then J
    add(1'b0, T_BEQ, 1'b1, E_FETCH);
    add(1'b0, T_BEQ, 1'b1, E_DECODE);
    add(1'b0, T_BEQ, 1'b1, E_BRANCH);
    add(1'b0, T_J, 1'b1, E_FETCH);
    add(1'b0, T_J, 1'b1, E_DECODE);
    add(1'b0, T_J, 1'b1, E_JUMP);
    // ADDI
    add(1'b0, T_ADI, 1'b1, E_FETCH);
    add(1'b0, T_ADI, 1'b1, E_DECODE);
    add(1'b0, T_ADI, 1'b1, E_ADDIEX);
    add(1'b0, T_ADI, 1'b1, E_ADDIWB);
    // Fetch wait, and mem_ready ignored outside memory states
    add(1'b0, T_J, 1'b0, E_FETCHW);
    add(1'b0, T_J, 1'b1, E_FETCH);
    add(1'b0, T_J, 1'b0, E_DECODE);
    add(1'b0, T_J, 1'b0, E_JUMP);
    // SW with reset during the write wait
    add(1'b0, T_SW, 1'b1, E_FETCH);
    add(1'b0, T_SW, 1'b1, E_DECODE);
    add(1'b0, T_SW, 1'b1, E_MEMADR);
    add(1'b0, T_SW, 1'b0, E_MEMWR);
    add(1'b1, T_SW, 1'b0, E_ZERO);
    add(1'b0, T_R, 1'b1, E_FETCH);
    add(1'b0, T_R, 1'b1, E_DECODE);
    add(1'b0, T_R, 1'b1, E_EXEC);
    add(1'b0, T_R, 1'b1, E_ALUWB);
    // Illegal opcode: absorbing trap until reset
    add(1'b0, T_BAD, 1'b1, E_FETCH);
    add(1'b0, T_BAD, 1'b1, E_DECODE);
    for (int k = 0; k < 12; k++) add(1'b0, (k % 2 == 0) ? T_R : T_LW, k[0], E_TRAP);
    add(1'b1, T_R, 1'b1, E_ZERO);
    add(1'b0, T_R, 1'b1, E_FETCH);
    add(1'b0, T_R, 1'b1, E_DECODE);
    add(1'b0, T_R, 1'b1, E_EXEC);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].exp, "vec", i);

    // Hand sequence: reset in the middle of a load's memory wait
    cyc(1'b0, T_R,  1'b1, E_ALUWB,  "lwrst", 0);
    cyc(1'b0, T_LW, 1'b1, E_FETCH,  "lwrst", 1);
    cyc(1'b0, T_LW, 1'b1, E_DECODE, "lwrst", 2);
    cyc(1'b0, T_LW, 1'b1, E_MEMADR, "lwrst", 3);
    cyc(1'b0, T_LW, 1'b0, E_MEMRD,  "lwrst", 4);
    cyc(1'b1, T_LW, 1'b1, E_ZERO,   "lwrst", 5);
    cyc(1'b0, T_LW, 1'b0, E_FETCHW, "lwrst", 6);
    cyc(1'b0, T_LW, 1'b1, E_FETCH,  "lwrst", 7);
    cyc(1'b0, T_LW, 1'b1, E_DECODE, "lwrst", 8);

    // Hand sequence: trap entered straight from reset, held, then cleared
    cyc(1'b1, T_BAD, 1'b1, E_ZERO,   "trap", 0);
    cyc(1'b0, T_BAD, 1'b1, E_FETCH,  "trap", 1);
    cyc(1'b0, T_BAD, 1'b0, E_DECODE, "trap", 2);
    cyc(1'b0, T_SW,  1'b1, E_TRAP,   "trap", 3);
    cyc(1'b0, T_SW,  1'b0, E_TRAP,   "trap", 4);
    cyc(1'b1, T_SW,  1'b0, E_ZERO,   "trap", 5);
    cyc(1'b0, T_BEQ, 1'b1, E_FETCH,  "trap", 6);
    cyc(1'b0, T_BEQ, 1'b1, E_DECODE, "trap", 7);
    cyc(1'b0, T_BEQ, 1'b1, E_BRANCH, "trap", 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
